// File: rtl/dance_pkg.sv
// Shared definitions for the arrow-note game: state encoding, geometry defaults
// and the lane/row to grid-bit mapping.
// No ports; pure compile-time package with no latency or flow control.
package dance_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_e;

    localparam int LANES_DEF = 4;
    localparam int ROWS_DEF  = 8;

    // Grid bit for (lane, row); lanes are laid out as contiguous ROWS-bit groups
    // with row 0 (top) at the low end of each group.
    function automatic int bit_idx(input int lane, input int row, input int rows);
        return lane * rows + row;
    endfunction

endpackage

// File: rtl/note_scroller_step_divider.sv
// Scroll-step divider: counts 0..TICK_DIV-1 while enabled, step high on the last count.
// Latency: step is a combinational decode of the count register; clr/!en zero it next edge.
// Backpressure: none; free-running while enabled.
// Ports: clk, rst (async, active-high), en (count), clr (force to 0), step (out).
module step_divider #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic step
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] tick_q;
    logic [CW-1:0] tick_d;

    always_comb begin
        tick_d = tick_q;
        if (clr || !en) begin
            tick_d = '0;
        end else if (tick_q == LAST) begin
            tick_d = '0;
        end else begin
            tick_d = tick_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign step = en && (tick_q == LAST);

endmodule

// File: rtl/note_scroller.sv
// Falling-arrow game core: spawns notes from the LFSR word, scrolls them, judges key presses.
// Latency: all outputs registered; hit/miss pulses appear one cycle after the deciding cycle.
// Backpressure: none; key/start are single-cycle pulses, rnd is sampled only on step cycles.
// Ports: clk, rst (async, active-high), rnd[6:0], start, key[LANES-1:0] in;
//        grid[LANES*ROWS-1:0] (bit lane*ROWS+row), score, misses, playing, game_over,
//        hit_pulse, miss_pulse out.
module note_scroller
    import dance_pkg::*;
#(
    parameter int LANES        = LANES_DEF,
    parameter int ROWS         = ROWS_DEF,
    parameter int TICK_DIV     = 50000,
    parameter int SPAWN_THRESH = 64,
    parameter int MAX_MISS     = 8,
    parameter int SCORE_W      = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            rnd,
    input  logic                  start,
    input  logic [LANES-1:0]      key,
    output logic [LANES*ROWS-1:0] grid,
    output logic [SCORE_W-1:0]    score,
    output logic [3:0]            misses,
    output logic                  playing,
    output logic                  game_over,
    output logic                  hit_pulse,
    output logic                  miss_pulse
);

    localparam logic [3:0] MISS_LIM  = 4'(MAX_MISS);
    localparam logic [5:0] SPAWN_LIM = 6'(SPAWN_THRESH / 4);

    state_e                  state_q, state_d;
    logic [LANES*ROWS-1:0]   grid_q, grid_d;
    logic [SCORE_W-1:0]      score_q, score_d;
    logic [3:0]              misses_q, misses_d;
    logic                    hit_pulse_q, hit_pulse_d;
    logic                    miss_pulse_q, miss_pulse_d;
    logic                    playing_q, playing_d;
    logic                    over_q, over_d;

    logic                    tick_en;
    logic                    tick_clr;
    logic                    step;
    logic [LANES*ROWS-1:0]   work;
    logic [2:0]              hit_cnt;
    logic [2:0]              miss_cnt;
    logic [SCORE_W:0]        score_sum;
    logic [4:0]              miss_sum;

    step_divider #(.TICK_DIV(TICK_DIV)) u_div (
        .clk  (clk),
        .rst  (rst),
        .en   (tick_en),
        .clr  (tick_clr),
        .step (step)
    );

    always_comb begin
        state_d      = state_q;
        grid_d       = grid_q;
        score_d      = score_q;
        misses_d     = misses_q;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;
        tick_en      = 1'b0;
        tick_clr     = 1'b0;
        work         = grid_q;
        hit_cnt      = 3'd0;
        miss_cnt     = 3'd0;
        score_sum    = '0;
        miss_sum     = '0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d  = ST_PLAY;
                    grid_d   = '0;
                    score_d  = '0;
                    misses_d = '0;
                    tick_clr = 1'b1;
                end
            end
            ST_PLAY: begin
                // The miss that hit the limit was registered last cycle; leave
                // now without touching grid/score so the final picture freezes.
                if (misses_q >= MISS_LIM) begin
                    state_d = ST_OVER;
                end else begin
                    tick_en = 1'b1;
                    // Key judgment first, so a press on a step cycle rescues the note.
                    for (int l = 0; l < LANES; l++) begin
                        if (key[l] && work[bit_idx(l, ROWS - 1, ROWS)]) begin
                            work[bit_idx(l, ROWS - 1, ROWS)] = 1'b0;
                            hit_cnt = hit_cnt + 3'd1;
                        end
                    end
                    if (step) begin
                        for (int l = 0; l < LANES; l++) begin
                            if (work[bit_idx(l, ROWS - 1, ROWS)]) begin
                                miss_cnt = miss_cnt + 3'd1;
                            end
                            for (int r = ROWS - 1; r > 0; r--) begin
                                work[bit_idx(l, r, ROWS)] = work[bit_idx(l, r - 1, ROWS)];
                            end
                            work[bit_idx(l, 0, ROWS)] = 1'b0;
                        end
                        if ({1'b0, rnd[6:2]} < SPAWN_LIM) begin
                            work[bit_idx(int'(rnd[1:0]), 0, ROWS)] = 1'b1;
                        end
                    end
                    grid_d = work;

                    score_sum = {1'b0, score_q} + (SCORE_W + 1)'(hit_cnt);
                    score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                    miss_sum  = {1'b0, misses_q} + 5'(miss_cnt);
                    misses_d  = miss_sum[4] ? 4'hF : miss_sum[3:0];

                    hit_pulse_d  = (hit_cnt != 3'd0);
                    miss_pulse_d = (miss_cnt != 3'd0);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        playing_d = (state_d == ST_PLAY);
        over_d    = (state_d == ST_OVER);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grid_q       <= '0;
            score_q      <= '0;
            misses_q     <= '0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            playing_q    <= 1'b0;
            over_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grid_q       <= grid_d;
            score_q      <= score_d;
            misses_q     <= misses_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            playing_q    <= playing_d;
            over_q       <= over_d;
        end
    end

    assign grid       = grid_q;
    assign score      = score_q;
    assign misses     = misses_q;
    assign playing    = playing_q;
    assign game_over  = over_q;
    assign hit_pulse  = hit_pulse_q;
    assign miss_pulse = miss_pulse_q;

endmodule
